// File: rtl/fft_bin_serializer_if.sv
`default_nettype none
// ============================================================================
// Module   : fft_bin_serializer_if
// Brief    : Valid/ready bin stream from the FFT serializer to the demapper.
//            Carries the o_mag lane only when FFT_SER_MAG_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
interface fft_bin_serializer_if #(
    parameter int WORD_SIZE = 16
);
    logic [WORD_SIZE-1:0] re;
    logic [WORD_SIZE-1:0] im;
    logic [3:0]           idx;
    logic                 valid;
    logic                 last;
    logic                 ready;
`ifdef FFT_SER_MAG_EN
    logic [WORD_SIZE:0]   mag;
`endif

    modport master (
        output re,
        output im,
        output idx,
        output valid,
        output last,
`ifdef FFT_SER_MAG_EN
        output mag,
`endif
        input  ready
    );

    modport slave (
        input  re,
        input  im,
        input  idx,
        input  valid,
        input  last,
`ifdef FFT_SER_MAG_EN
        input  mag,
`endif
        output ready
    );
endinterface
`default_nettype wire

// File: rtl/fft_bin_serializer.sv
`default_nettype none
// ============================================================================
// Module   : fft_bin_serializer
// Brief    : Captures a 16-bin FFT frame and streams it in natural bin order;
//            flags frames lost while streaming. FFT_SER_MAG_EN adds o_mag.
// Revision : 1.0 - initial release
// ============================================================================
module fft_bin_serializer #(
    parameter int WORD_SIZE   = 16,
    parameter int FRACTION    = 8,
    parameter int POINTS      = 16,
    parameter int BIT_REVERSE = 1
) (
    input  wire logic                        i_clk,
    input  wire logic                        i_rst,
    input  wire logic [POINTS*WORD_SIZE-1:0] i_bins_re,
    input  wire logic [POINTS*WORD_SIZE-1:0] i_bins_im,
    input  wire logic                        i_frame_valid,
    fft_bin_serializer_if.master             o_stream,
    output logic                             o_busy,
    output logic                             o_overflow
);

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_STREAM = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [3:0]           r_count;
    logic [WORD_SIZE-1:0] r_bank_re [POINTS];
    logic [WORD_SIZE-1:0] r_bank_im [POINTS];
    logic                 r_overflow;

    logic                 w_valid;
    logic                 w_xfer;
    logic                 w_final;
    logic                 w_load;
    logic                 w_drop;
    logic [3:0]           w_rd_addr;
    logic [WORD_SIZE-1:0] w_re;
    logic [WORD_SIZE-1:0] w_im;

    if (FRACTION >= WORD_SIZE || POINTS != 16) begin : g_param_check
        $error("fft_bin_serializer: POINTS must be 16 and FRACTION < WORD_SIZE");
    end

    // Bin k of the FFT output lives in slot bitrev4(k) when BIT_REVERSE is set.
    if (BIT_REVERSE != 0) begin : g_bitrev
        assign w_rd_addr = {r_count[0], r_count[1], r_count[2], r_count[3]};
    end else begin : g_natural
        assign w_rd_addr = r_count;
    end

    assign w_valid = (r_state == S_STREAM);
    assign w_xfer  = w_valid && o_stream.ready;
    assign w_final = w_xfer && (r_count == 4'hF);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A pulse landing on the final transfer chains frames without a bubble.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_drop      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_frame_valid) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_STREAM;
                end
            end
            S_STREAM: begin
                if (w_final) begin
                    if (i_frame_valid) begin
                        w_load = 1'b1;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else if (i_frame_valid) begin
                    w_drop = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count    <= 4'd0;
            r_overflow <= 1'b0;
            for (int k = 0; k < POINTS; k++) begin
                r_bank_re[k] <= '0;
                r_bank_im[k] <= '0;
            end
        end else begin
            if (w_load) begin
                r_count <= 4'd0;
                for (int k = 0; k < POINTS; k++) begin
                    r_bank_re[k] <= i_bins_re[k*WORD_SIZE +: WORD_SIZE];
                    r_bank_im[k] <= i_bins_im[k*WORD_SIZE +: WORD_SIZE];
                end
            end else if (w_xfer) begin
                r_count <= r_count + 4'd1;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign w_re = w_valid ? r_bank_re[w_rd_addr] : '0;
    assign w_im = w_valid ? r_bank_im[w_rd_addr] : '0;

    assign o_stream.re    = w_re;
    assign o_stream.im    = w_im;
    assign o_stream.idx   = w_valid ? r_count : 4'd0;
    assign o_stream.valid = w_valid;
    assign o_stream.last  = w_valid && (r_count == 4'hF);
    assign o_busy         = w_valid;
    assign o_overflow     = r_overflow;

`ifdef FFT_SER_MAG_EN
    logic [WORD_SIZE:0] w_ext_re;
    logic [WORD_SIZE:0] w_ext_im;
    logic [WORD_SIZE:0] w_abs_re;
    logic [WORD_SIZE:0] w_abs_im;
    logic [WORD_SIZE:0] w_max;
    logic [WORD_SIZE:0] w_min;

    // One extra bit keeps |most negative| representable.
    assign w_ext_re = {w_re[WORD_SIZE-1], w_re};
    assign w_ext_im = {w_im[WORD_SIZE-1], w_im};
    assign w_abs_re = w_re[WORD_SIZE-1] ? (~w_ext_re + 1'b1) : w_ext_re;
    assign w_abs_im = w_im[WORD_SIZE-1] ? (~w_ext_im + 1'b1) : w_ext_im;
    assign w_max    = (w_abs_re >= w_abs_im) ? w_abs_re : w_abs_im;
    assign w_min    = (w_abs_re >= w_abs_im) ? w_abs_im : w_abs_re;
    assign o_stream.mag = w_max + (w_min >> 1);
`endif

endmodule
`default_nettype wire

// File: tb/tb_fft_bin_serializer.sv
`default_nettype none
// Self-checking bench for fft_bin_serializer: scoreboard of expected words
// pushed at frame capture and popped on every accepted output transfer.
module tb_fft_bin_serializer;

    localparam int c_W = 16;
    localparam int c_N = 16;

    typedef struct {
        logic [3:0]  idx;
        logic [15:0] re;
        logic [15:0] im;
        logic [16:0] mag;
    } exp_t;

    logic               clk;
    logic               rst;
    logic [c_N*c_W-1:0] bins_re;
    logic [c_N*c_W-1:0] bins_im;
    logic               frame_valid;
    logic               busy;
    logic               overflow;

    fft_bin_serializer_if #(.WORD_SIZE(c_W)) u_if ();

    fft_bin_serializer #(
        .WORD_SIZE  (c_W),
        .FRACTION   (8),
        .POINTS     (c_N),
        .BIT_REVERSE(1)
    ) u_dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_bins_re    (bins_re),
        .i_bins_im    (bins_im),
        .i_frame_valid(frame_valid),
        .o_stream     (u_if),
        .o_busy       (busy),
        .o_overflow   (overflow)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    exp_t        sb_q[$];
    logic [15:0] fr_re[c_N];
    logic [15:0] fr_im[c_N];
    logic        held_v;
    logic [35:0] held_w;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp_v, $time);
        end
    endtask

    function automatic logic [3:0] bitrev(input logic [3:0] n);
        return {n[0], n[1], n[2], n[3]};
    endfunction

    function automatic logic [16:0] mag_model(input logic [15:0] re, input logic [15:0] im);
        int a;
        int b;
        int mx;
        int mn;
        a  = int'($signed(re));
        b  = int'($signed(im));
        if (a < 0) a = -a;
        if (b < 0) b = -b;
        mx = (a > b) ? a : b;
        mn = (a > b) ? b : a;
        return 17'(mx + mn / 2);
    endfunction

    // Called just after a rising edge; the pulse is captured at the next edge.
    task automatic send_frame(input bit expect_it, input bit chk_lat);
        exp_t e;
        for (int k = 0; k < c_N; k++) begin
            bins_re[k*c_W +: c_W] = fr_re[k];
            bins_im[k*c_W +: c_W] = fr_im[k];
        end
        if (expect_it) begin
            for (int n = 0; n < c_N; n++) begin
                e.idx = 4'(n);
                e.re  = fr_re[bitrev(4'(n))];
                e.im  = fr_im[bitrev(4'(n))];
                e.mag = mag_model(e.re, e.im);
                sb_q.push_back(e);
            end
        end
        frame_valid = 1'b1;
        @(posedge clk);
        #1;
        frame_valid = 1'b0;
        if (chk_lat) begin
            check("first_valid", u_if.valid, 1'b1);
            check("first_idx", u_if.idx, 4'd0);
        end
    endtask

    task automatic rand_frame();
        for (int k = 0; k < c_N; k++) begin
            fr_re[k] = 16'($urandom);
            fr_im[k] = 16'($urandom);
        end
    endtask

    task automatic wait_idx(input logic [3:0] n);
        bit found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (u_if.valid && u_if.idx == n) found = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        if (!found) check("wait_idx_timeout", {u_if.valid, u_if.idx}, {1'b1, n});
    endtask

    task automatic drain(input bit bp);
        bit done = 1'b0;
        logic [3:0] pat;
        pat = 4'b1001;
        for (int c = 0; c < 300 && !done; c++) begin
            if (!u_if.valid && sb_q.size() == 0) done = 1'b1;
            else begin
                @(posedge clk);
                #1;
                if (bp) u_if.ready = pat[c % 4];
            end
        end
        u_if.ready = 1'b1;
        if (!done) check("drain_timeout", 64'(sb_q.size()), 64'd0);
        check("valid_after_drain", u_if.valid, 1'b0);
    endtask

    // Monitor: pops one expectation per accepted word; holds must be stable.
    always @(negedge clk) begin
        automatic exp_t e;
        if (rst) begin
            held_v <= 1'b0;
        end else begin
            if (held_v) begin
                check("hold_valid", u_if.valid, 1'b1);
                check("hold_data", {u_if.idx, u_if.re, u_if.im}, held_w);
            end
            if (u_if.valid) begin
                check("busy", busy, 1'b1);
                check("last", u_if.last, u_if.idx == 4'hF);
                if (u_if.ready) begin
                    held_v <= 1'b0;
                    if (sb_q.size() == 0) begin
                        check("sb_unexpected_word", 64'(sb_q.size()), 64'd1);
                    end else begin
                        e = sb_q.pop_front();
                        check("idx", u_if.idx, e.idx);
                        check("re", u_if.re, e.re);
                        check("im", u_if.im, e.im);
`ifdef FFT_SER_MAG_EN
                        check("mag", u_if.mag, e.mag);
`endif
                    end
                end else begin
                    held_v <= 1'b1;
                    held_w <= {u_if.idx, u_if.re, u_if.im};
                end
            end else begin
                held_v <= 1'b0;
                check("last_idle", u_if.last, 1'b0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst         = 1'b1;
        bins_re     = '0;
        bins_im     = '0;
        frame_valid = 1'b0;
        u_if.ready  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", u_if.valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_ovf", overflow, 1'b0);
        check("rst_re_im", {u_if.re, u_if.im}, 32'd0);
        check("rst_idx_last", {u_if.idx, u_if.last}, 5'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Natural-order recovery: slot k re = k.0 in Q8, im = -k.
        for (int k = 0; k < c_N; k++) begin
            fr_re[k] = 16'(k * 256);
            fr_im[k] = 16'(-k);
        end
        send_frame(1'b1, 1'b1);
        wait_idx(4'd1);
        check("idx1_re", u_if.re, 16'h0800);
        wait_idx(4'd15);
        check("idx15_re", u_if.re, 16'h0F00);
        check("idx15_last", u_if.last, 1'b1);
        drain(1'b0);

        // Backpressure with ready pattern 1,0,0,1.
        rand_frame();
        send_frame(1'b1, 1'b1);
        drain(1'b1);

        // Back-to-back: second pulse on the idx15 transfer.
        rand_frame();
        send_frame(1'b1, 1'b1);
        wait_idx(4'd15);
        rand_frame();
        send_frame(1'b1, 1'b0);
        check("b2b_valid", u_if.valid, 1'b1);
        check("b2b_idx", u_if.idx, 4'd0);
        check("b2b_ovf", overflow, 1'b0);
        drain(1'b0);
        check("b2b_ovf_end", overflow, 1'b0);

        // Overflow: pulse at idx5 is dropped, first frame keeps streaming.
        rand_frame();
        send_frame(1'b1, 1'b1);
        wait_idx(4'd5);
        rand_frame();
        send_frame(1'b0, 1'b0);
        check("ovf_set", overflow, 1'b1);
        drain(1'b0);
        check("ovf_sticky", overflow, 1'b1);

        // Asynchronous reset mid-stream at idx7.
        rand_frame();
        send_frame(1'b1, 1'b1);
        wait_idx(4'd7);
        rst = 1'b1;
        #1;
        check("amid_valid", u_if.valid, 1'b0);
        check("amid_busy", busy, 1'b0);
        check("amid_ovf", overflow, 1'b0);
        check("amid_idx", u_if.idx, 4'd0);
        sb_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        rand_frame();
        send_frame(1'b1, 1'b1);
        drain(1'b0);

`ifdef FFT_SER_MAG_EN
        check("mag_idle", u_if.mag, 17'd0);
        rand_frame();
        fr_re[0] = 16'h0300;
        fr_im[0] = 16'hFC00;
        fr_re[1] = 16'h8000;
        fr_im[1] = 16'h0000;
        send_frame(1'b1, 1'b1);
        check("mag_3_m4", u_if.mag, 17'h00580);
        wait_idx(4'd8);
        check("mag_most_neg", u_if.mag, 17'h08000);
        drain(1'b0);
`endif

        check("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
